// File: rtl/adc_scan_sequencer_pkg.sv
// Shared definitions for the LTC2308 scan sequencer: conf bit layout,
// FSM state encoding and the per-channel conf builder.
package adc_scan_sequencer_pkg;

  localparam int CONF_W   = 6;
  localparam int CONF_SD  = 5;
  localparam int CONF_OS  = 4;
  localparam int CONF_S1  = 3;
  localparam int CONF_S0  = 2;
  localparam int CONF_UNI = 1;
  localparam int CONF_SLP = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } scan_state_e;

  // Single-ended conf word for channel n; the ADC never sleeps between scans.
  function automatic logic [CONF_W-1:0] conf_for_ch(input logic [2:0] ch, input logic uni);
    logic [CONF_W-1:0] c;
    c           = 6'b000000;
    c[CONF_SD]  = 1'b1;
    c[CONF_OS]  = ch[0];
    c[CONF_S1]  = ch[2];
    c[CONF_S0]  = ch[1];
    c[CONF_UNI] = uni;
    c[CONF_SLP] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// Round-robin channel picker: finds the next set bit of mask strictly after
// cur, wrapping 7->0. A single-bit mask equal to cur returns cur itself.
module adc_ch_pick (
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] next,
  output logic       any
);

  logic [2:0] idx_s;
  logic       found_s;

  // Scan the eight candidates in order cur+1 .. cur+8 and keep the first hit.
  always_comb begin
    next    = cur;
    idx_s   = 3'd0;
    found_s = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx_s = cur + 3'(i);
      if (!found_s && mask[idx_s]) begin
        found_s = 1'b1;
        next    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer in front of the LTC2308 SPI driver. Round-robins over the
// enabled channels, re-attributes each result to the channel requested one
// transfer earlier (the ADC's conf pipeline), averages 2**AVG_LOG2 samples per
// channel and publishes into a per-channel result file.
module adc_scan_sequencer
  import adc_scan_sequencer_pkg::*;
#(
  parameter int W        = 12,
  parameter int AVG_LOG2 = 2,
  parameter int GAP      = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    ch_mask,
  input  logic          uni,
  output logic          adc_start,
  output logic [5:0]    adc_conf,
  input  logic [W-1:0]  adc_res,
  input  logic          adc_ready,
  input  logic [2:0]    rd_ch,
  output logic [W-1:0]  rd_data,
  output logic          upd,
  output logic [2:0]    upd_ch,
  output logic [W-1:0]  upd_data,
  output logic          busy,
  output logic          timeout
);

  localparam int ACC_W = W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  scan_state_e        state_r, state_nxt_s;
  logic [2:0]         cur_ch_r, req_ch_r, prev_ch_r;
  logic [2:0]         pick_ch_s;
  logic               pick_any_s, take_pick_s;
  logic               prime_r, ready_d_r;
  logic               start_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               ready_rise_s, cap_s, tmo_hit_s, gap_done_s, gap_to_idle_s;
  logic               credit_s, last_s;
  logic [ACC_W-1:0]   sum_s;
  logic [W-1:0]       avg_s;
  logic [ACC_W-1:0]   acc_r    [8];
  logic [CNT_W-1:0]   cnt_r    [8];
  logic [W-1:0]       result_r [8];
  logic               adc_start_r, upd_r, busy_r, timeout_r;
  logic [5:0]         adc_conf_r;
  logic [2:0]         upd_ch_r;
  logic [W-1:0]       upd_data_r;

  adc_ch_pick u_pick (
    .mask (ch_mask),
    .cur  (cur_ch_r),
    .next (pick_ch_s),
    .any  (pick_any_s)
  );

  // Event decode: ready edges only count while waiting on our own transfer.
  always_comb begin
    ready_rise_s  = adc_ready && !ready_d_r;
    cap_s         = (state_r == ST_WAIT) && ready_rise_s;
    tmo_hit_s     = (state_r == ST_WAIT) && !ready_rise_s && (tmo_cnt_r == TMO_LAST);
    gap_done_s    = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);
    gap_to_idle_s = gap_done_s && !(en && pick_any_s);
    credit_s      = cap_s && prime_r;
    last_s        = (cnt_r[prev_ch_r] == CNT_LAST);
    sum_s         = acc_r[prev_ch_r] + ACC_W'(adc_res);
    avg_s         = W'(sum_s >> AVG_LOG2);
  end

  // Next-state logic; a channel pick happens on every entry into START.
  always_comb begin
    state_nxt_s = state_r;
    take_pick_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && pick_any_s) begin
          state_nxt_s = ST_START;
          take_pick_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (start_cnt_r == 1'b1) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_WAIT: begin
        if (ready_rise_s || tmo_hit_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_done_s && en && pick_any_s) begin
          state_nxt_s = ST_START;
          take_pick_s = 1'b1;
        end else if (gap_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus outputs derived from the next state so they are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      adc_start_r <= 1'b0;
      busy_r      <= 1'b0;
      ready_d_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      adc_start_r <= (state_nxt_s == ST_START);
      busy_r      <= (state_nxt_s != ST_IDLE);
      ready_d_r   <= adc_ready;
    end
  end

  // Channel bookkeeping: prev_ch takes the outgoing request so captures land on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch_r   <= 3'd7;
      req_ch_r   <= 3'd0;
      prev_ch_r  <= 3'd0;
      adc_conf_r <= 6'b000000;
    end else if (take_pick_s) begin
      cur_ch_r   <= pick_ch_s;
      req_ch_r   <= pick_ch_s;
      prev_ch_r  <= req_ch_r;
      adc_conf_r <= conf_for_ch(pick_ch_s, uni);
    end else begin
      cur_ch_r   <= cur_ch_r;
      req_ch_r   <= req_ch_r;
      prev_ch_r  <= prev_ch_r;
      adc_conf_r <= adc_conf_r;
    end
  end

  // Per-state clock counters; each is zero whenever its state is not active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_cnt_r <= 1'b0;
      tmo_cnt_r   <= '0;
      gap_cnt_r   <= '0;
    end else begin
      if (state_r == ST_START) begin
        start_cnt_r <= start_cnt_r + 1'b1;
      end else begin
        start_cnt_r <= 1'b0;
      end
      if ((state_r == ST_START) || (state_r == ST_WAIT)) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
        tmo_cnt_r <= '0;
      end
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= '0;
      end
    end
  end

  // Pipeline priming and the sticky timeout flag; a lost or restarted scan re-primes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (tmo_hit_s || gap_to_idle_s) begin
        prime_r <= 1'b0;
      end else if (cap_s) begin
        prime_r <= 1'b1;
      end else begin
        prime_r <= prime_r;
      end
      if (!en) begin
        timeout_r <= 1'b0;
      end else if (tmo_hit_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  // Accumulate credited samples; the final sample of a block folds straight into the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        acc_r[i]    <= '0;
        cnt_r[i]    <= '0;
        result_r[i] <= '0;
      end
    end else if (credit_s) begin
      if (last_s) begin
        acc_r[prev_ch_r]    <= '0;
        cnt_r[prev_ch_r]    <= '0;
        result_r[prev_ch_r] <= avg_s;
      end else begin
        acc_r[prev_ch_r]    <= sum_s;
        cnt_r[prev_ch_r]    <= cnt_r[prev_ch_r] + CNT_W'(1);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        acc_r[i]    <= acc_r[i];
        cnt_r[i]    <= cnt_r[i];
        result_r[i] <= result_r[i];
      end
    end
  end

  // Publish strobe, one clock after the capture that completes a block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_r      <= 1'b0;
      upd_ch_r   <= 3'd0;
      upd_data_r <= '0;
    end else if (credit_s && last_s) begin
      upd_r      <= 1'b1;
      upd_ch_r   <= prev_ch_r;
      upd_data_r <= avg_s;
    end else begin
      upd_r      <= 1'b0;
      upd_ch_r   <= upd_ch_r;
      upd_data_r <= upd_data_r;
    end
  end

  assign adc_start = adc_start_r;
  assign adc_conf  = adc_conf_r;
  assign upd       = upd_r;
  assign upd_ch    = upd_ch_r;
  assign upd_data  = upd_data_r;
  assign busy      = busy_r;
  assign timeout   = timeout_r;
  assign rd_data   = result_r[rd_ch];

endmodule
